// File: rtl/bcd_to_binary.sv
// bcd_to_binary: three-digit BCD to binary converter, one reverse double-dabble step per clock.
// Build option: define BCD2BIN_SAT_EN to saturate binary_out on overflow (default wraps).
`default_nettype none

module bcd_to_binary #(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_en,
  input  logic [3:0]       H,
  input  logic [3:0]       T,
  input  logic [3:0]       O,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] binary_out,
  output logic             ovf,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [10:0] c_MAX_VAL   = 11'((1 << OUT_W) - 1);
  localparam logic [3:0]  c_LAST_STEP = 4'd11;

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_bcd;
  // Twelve shifts move twelve bits out of the BCD side; a 12-bit accumulator keeps
  // the two earliest (least significant) result bits that a 10-bit one would drop.
  logic [11:0] r_acc;
  logic [3:0]  r_cnt;

  logic [23:0]      w_shifted;
  logic [11:0]      w_bcd_corr;
  logic [9:0]       w_value;
  logic             w_ovf;
  logic             w_digit_bad;
  logic             w_first;
  logic             w_last;
  logic [OUT_W-1:0] w_out;

  always_comb begin
    w_shifted  = {1'b0, r_bcd, r_acc[11:1]};
    w_bcd_corr = w_shifted[23:12];
    for (int i = 0; i < 3; i++) begin
      if (w_shifted[12 + 4*i +: 4] >= 4'd8) begin
        w_bcd_corr[4*i +: 4] = w_shifted[12 + 4*i +: 4] - 4'd3;
      end
    end
  end

  assign w_value     = w_shifted[9:0];
  assign w_ovf       = ({1'b0, w_value} > c_MAX_VAL);
  assign w_digit_bad = (r_bcd[11:8] > 4'd9) || (r_bcd[7:4] > 4'd9) || (r_bcd[3:0] > 4'd9);
  assign w_first     = (r_cnt == 4'd0);
  assign w_last      = (r_cnt == c_LAST_STEP);

`ifdef BCD2BIN_SAT_EN
  assign w_out = w_ovf ? {OUT_W{1'b1}} : w_value[OUT_W-1:0];
`else
  assign w_out = w_value[OUT_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_en) begin
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if ((w_first && w_digit_bad) || w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // The digit check runs on the latched copy during the first SHIFT cycle, so an
  // invalid request reports done one cycle after its start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd      <= 12'd0;
      r_acc      <= 12'd0;
      r_cnt      <= 4'd0;
      binary_out <= '0;
      ovf        <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_en) begin
            r_bcd <= {H, T, O};
            r_acc <= 12'd0;
            r_cnt <= 4'd0;
          end
        end
        S_SHIFT: begin
          if (w_first && w_digit_bad) begin
            binary_out <= '0;
            ovf        <= 1'b0;
            err        <= 1'b1;
          end else begin
            r_bcd <= w_bcd_corr;
            r_acc <= w_shifted[11:0];
            r_cnt <= r_cnt + 4'd1;
            if (w_last) begin
              binary_out <= w_out;
              ovf        <= w_ovf;
              err        <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: directed checks of bcd_to_binary (OUT_W = 8) with immediate assertions.
`default_nettype none

module tb_bcd_to_binary;

  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_en;
  logic [3:0]       H;
  logic [3:0]       T;
  logic [3:0]       O;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] binary_out;
  logic             ovf;
  logic             err;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  bcd_to_binary #(.OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_en   (start_en),
    .H          (H),
    .T          (T),
    .O          (O),
    .busy       (busy),
    .done       (done),
    .binary_out (binary_out),
    .ovf        (ovf),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request; inputs are scrambled right after the latching edge.
  task automatic conv(input string tag, input logic [3:0] h, input logic [3:0] t,
                      input logic [3:0] o, input logic [7:0] e_out, input logic e_ovf,
                      input logic e_err, input int e_lat);
    int lat;
    bit busy_ok;
    @(negedge clk);
    H = h; T = t; O = o; start_en = 1'b1;
    @(posedge clk); #1;
    start_en = 1'b0; H = 4'h9; T = 4'hF; O = 4'h9;
    chk({tag, "/busy_rise"}, busy, 1);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!busy) busy_ok = 1'b0;
    end
    chk({tag, "/latency"}, lat, e_lat);
    chk({tag, "/busy_held"}, busy_ok, 1);
    chk({tag, "/binary_out"}, binary_out, e_out);
    chk({tag, "/ovf"}, ovf, e_ovf);
    chk({tag, "/err"}, err, e_err);
    @(posedge clk); #1;
    chk({tag, "/done_fall"}, done, 0);
    chk({tag, "/busy_fall"}, busy, 0);
    chk({tag, "/out_hold"}, binary_out, e_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    int  pulses;
    bit  vals_ok;
    bit  seen_done;

    rst = 1'b1; start_en = 1'b0; H = 4'd0; T = 4'd0; O = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/busy", busy, 0);
    chk("reset/done", done, 0);
    chk("reset/binary_out", binary_out, 0);
    chk("reset/ovf", ovf, 0);
    chk("reset/err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    conv("c225", 4'd2, 4'd2, 4'd5, 8'hE1, 1'b0, 1'b0, 12);
    conv("c000", 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 12);
    conv("c009", 4'd0, 4'd0, 4'd9, 8'h09, 1'b0, 1'b0, 12);
`ifdef BCD2BIN_SAT_EN
    conv("c999", 4'd9, 4'd9, 4'd9, 8'hFF, 1'b1, 1'b0, 12);
    conv("c256", 4'd2, 4'd5, 4'd6, 8'hFF, 1'b1, 1'b0, 12);
`else
    conv("c999", 4'd9, 4'd9, 4'd9, 8'hE7, 1'b1, 1'b0, 12);
    conv("c256", 4'd2, 4'd5, 4'd6, 8'h00, 1'b1, 1'b0, 12);
`endif
    conv("c255", 4'd2, 4'd5, 4'd5, 8'hFF, 1'b0, 1'b0, 12);
    conv("c864", 4'd8, 4'd6, 4'd4, 8'h60, 1'b1, 1'b0, 12);
    conv("badT", 4'd3, 4'hA, 4'd1, 8'h00, 1'b0, 1'b1, 1);
    conv("c187", 4'd1, 4'd8, 4'd7, 8'hBB, 1'b0, 1'b0, 12);

    // start_en pulse in the middle of a conversion must be ignored.
    @(negedge clk);
    H = 4'd0; T = 4'd4; O = 4'd2; start_en = 1'b1;
    @(posedge clk); #1;
    start_en = 1'b0; H = 4'd9; T = 4'd9; O = 4'd9;
    lat = 0;
    repeat (5) begin
      @(posedge clk); #1;
      lat++;
    end
    start_en = 1'b1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      start_en = 1'b0;
    end
    chk("midstart/latency", lat, 12);
    chk("midstart/binary_out", binary_out, 8'h2A);
    chk("midstart/ovf", ovf, 0);
    @(posedge clk); #1;
    chk("midstart/idle", busy, 0);

    // start_en held high: back-to-back conversions, each with a correct result.
    @(negedge clk);
    H = 4'd0; T = 4'd1; O = 4'd7; start_en = 1'b1;
    pulses  = 0;
    vals_ok = 1'b1;
    repeat (45) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (binary_out !== 8'h11 || ovf !== 1'b0 || err !== 1'b0) vals_ok = 1'b0;
      end
    end
    start_en = 1'b0;
    chk("held/done_count", pulses, 3);
    chk("held/values", vals_ok, 1);
    lat = 0;
    while (busy && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("held/drain", busy, 0);

    // Asynchronous reset at step 6 of a conversion.
    @(negedge clk);
    H = 4'd1; T = 4'd2; O = 4'd3; start_en = 1'b1;
    @(posedge clk); #1;
    start_en = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset/busy", busy, 0);
    chk("midreset/done", done, 0);
    chk("midreset/binary_out", binary_out, 0);
    chk("midreset/ovf", ovf, 0);
    chk("midreset/err", err, 0);
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    chk("midreset/no_done", seen_done, 0);
    @(negedge clk);
    rst = 1'b0;
    conv("after_reset", 4'd1, 4'd2, 4'd3, 8'h7B, 1'b0, 1'b0, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
